sgdmac_ar_scheduler: RTL and testbench
======================================

# sgdmac_ar_scheduler

N-requester scheduler for the shared AXI read-address (AR) channel of the scatter-gather DMA engine, sitting between the descriptor fetcher/read engines and the AXI master port. Grants AR issue round-robin, caps outstanding read bursts per requester, and routes the R channel back to the owning requester by ID. The requester index is the AXI ID, so responses need no reorder logic.

## Interface

Parameters:
- N_REQ, 2, number of requesters (2..16); requester i always issues with ID i
- DATA_W, 41, AR payload width per requester, packed {addr[31:0], len[3:0], size[2:0], burst[1:0]}
- MAX_OUTS, 4, maximum outstanding (AR accepted, last R beat not yet taken) bursts per requester; 1..15
- CW, $clog2(MAX_OUTS+1), width of each outstanding counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester AR request
- req_ready_o  out  N_REQ  one-hot accept pulse; request i is taken when req_valid_i[i] & req_ready_o[i]
- req_data_i  in  N_REQ*DATA_W  payload of requester i at [i*DATA_W +: DATA_W]
- arid_o  out  4  AXI AR ID (= granted index)
- ar_data_o  out  DATA_W  registered AR payload
- arvalid_o  out  1  AXI AR valid
- arready_i  in  1  AXI AR ready
- rid_i  in  4  AXI R ID
- rvalid_i  in  1  AXI R valid
- rlast_i  in  1  AXI R last
- rready_o  out  1  AXI R ready, routed from requester rid_i
- req_rready_i  in  N_REQ  per-requester R ready
- outs_cnt_o  out  N_REQ*CW  outstanding count of requester i at [i*CW +: CW]
- idle_o  out  1  no AR pending and all counters zero
- err_o  out  1  sticky protocol error flag

## Operation

- States: IDLE, ISSUE.
- eligible[i] = req_valid_i[i] & (cnt[i] < MAX_OUTS).
- IDLE: if any eligible, pick the first eligible index scanning ptr, ptr+1, ... mod N_REQ; assert req_ready_o[g] that cycle (combinational, one-hot); latch arid_o<=g, ar_data_o<=slice g; cnt[g]++; go ISSUE. No eligible: stay IDLE, req_ready_o=0.
- ISSUE: arvalid_o=1, arid_o/ar_data_o stable; req_ready_o=0. On arready_i: ptr<=(g+1) mod N_REQ, go IDLE.
- R routing: rready_o = req_rready_i[rid_i] if rid_i<N_REQ, else 1 (drain). Combinational.
- Decrement: rvalid_i & rready_o & rlast_i & rid_i<N_REQ -> cnt[rid_i]--.
- Same-cycle inc and dec of same counter: net unchanged. Inc and dec of different counters: both apply.
- Errors (set err_o, sticky until reset): R handshake with rid_i>=N_REQ; last beat for a requester whose cnt is 0 (counter stays 0, no underflow).
- idle_o = (state==IDLE) & all cnt==0.

## Timing

- Reset values: state IDLE, arvalid_o 0, arid_o 0, ar_data_o 0, ptr 0, all cnt 0, err_o 0; req_ready_o 0, idle_o 1.
- Request accept to arvalid_o: 1 cycle. Max AR rate: one per 2 cycles.
- arvalid_o never deasserts, and payload never changes, before arready_i (AXI rule).
- cnt visible on outs_cnt_o the cycle after accept/last beat.
- Counter at MAX_OUTS: requester masked from arbitration; may be regranted in the cycle after its decrement.
- Reset mid-ISSUE: arvalid_o drops immediately (async); pending burst is abandoned.

## Test plan

- Single request: N_REQ=2, req_valid_i=01, data addr 0x1000 len 3 -> req_ready_o=01 one cycle, next cycle arvalid_o=1, arid_o=0, ar_data_o payload matches; cnt0=1 after arready.
- Round-robin: both requesters valid continuously, arready_i=1 -> grant order 0,1,0,1; arid_o alternates.
- Limit: MAX_OUTS=4, requester 1 valid, no R beats -> exactly 4 grants, then req_ready_o stays 0; one rlast beat with rid 1 -> fifth grant next cycle.
- Backpressure: arready_i low 5 cycles -> arvalid_o held, payload stable, no new req_ready_o pulse.
- R routing: rid_i=1, req_rready_i=10 -> rready_o=1; rid_i=0 -> rready_o=0; rid_i=5 -> rready_o=1, err_o=1 and stays 1.
- Simultaneous: accept for requester 0 in same cycle as its rlast beat with cnt0=2 -> cnt0 remains 2.

Source files
------------

// File: rtl/sgdmac_ar_scheduler.sv
// Round-robin scheduler for the shared AXI AR channel. It caps outstanding
// bursts per requester and routes R-channel ready back by ID.
module sgdmac_ar_scheduler #(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = 41,
  parameter int MAX_OUTS = 4,
  parameter int CW       = $clog2(MAX_OUTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [3:0]              arid_o,
  output logic [DATA_W-1:0]       ar_data_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [3:0]              rid_i,
  input  logic                    rvalid_i,
  input  logic                    rlast_i,
  output logic                    rready_o,
  input  logic [N_REQ-1:0]        req_rready_i,
  output logic [N_REQ*CW-1:0]     outs_cnt_o,
  output logic                    idle_o,
  output logic                    err_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTS);

  logic [0:0]        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [3:0]        arid_q, arid_d;
  logic [DATA_W-1:0] ar_data_q, ar_data_d;
  logic [CW-1:0]     cnt_q [N_REQ];
  logic [CW-1:0]     cnt_d [N_REQ];
  logic              err_q, err_d;

  logic [N_REQ-1:0] eligible;
  logic             hi_found, lo_found, grant_found, accept;
  logic [3:0]       hi_idx, lo_idx, grant_idx;
  logic             rid_ok, r_last_hs, underflow;

  // Round-robin: lowest eligible index at or above ptr, else lowest overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < MAX_C);
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = 4'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = 4'(i);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
    accept      = (state_q == S_IDLE) && grant_found;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_o[i] = accept && (grant_idx == 4'(i));
    end
  end

  // IDs outside the requester range are drained so the interconnect never stalls.
  always_comb begin
    rid_ok   = 1'b0;
    rready_o = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (rid_i == 4'(i)) begin
        rid_ok   = 1'b1;
        rready_o = req_rready_i[i];
      end
    end
    r_last_hs = rvalid_i && rready_o && rlast_i && rid_ok;
  end

  always_comb begin
    underflow = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      logic inc, dec;
      inc = accept && (grant_idx == 4'(i));
      dec = r_last_hs && (rid_i == 4'(i)) && (cnt_q[i] != '0);
      if (r_last_hs && (rid_i == 4'(i)) && (cnt_q[i] == '0)) underflow = 1'b1;
      cnt_d[i] = cnt_q[i];
      if (inc && !dec)      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - CW'(1);
    end
    err_d = err_q | (rvalid_i && rready_o && !rid_ok) | underflow;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    arid_d    = arid_q;
    ar_data_d = ar_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          arid_d  = grant_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == 4'(i)) ar_data_d = req_data_i[i*DATA_W +: DATA_W];
          end
        end
      end
      default: begin
        if (arready_i) begin
          state_d = S_IDLE;
          ptr_d   = PW'((int'(arid_q) + 1) % N_REQ);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      arid_q    <= '0;
      ar_data_q <= '0;
      err_q     <= 1'b0;
      // NOTE: the counter array is reset because arbitration reads it right after reset.
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      arid_q    <= arid_d;
      ar_data_q <= ar_data_d;
      err_q     <= err_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    idle_o = (state_q == S_IDLE);
    for (int i = 0; i < N_REQ; i++) begin
      outs_cnt_o[i*CW +: CW] = cnt_q[i];
      if (cnt_q[i] != '0) idle_o = 1'b0;
    end
  end

  assign arvalid_o = (state_q == S_ISSUE);
  assign arid_o    = arid_q;
  assign ar_data_o = ar_data_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sgdmac_ar_scheduler.sv
// Bench for sgdmac_ar_scheduler: directed scenarios plus random traffic
// compared against a transaction-level model of the scheduler.
module tb_sgdmac_ar_scheduler;

  localparam int N_REQ    = 2;
  localparam int DATA_W   = 41;
  localparam int MAX_OUTS = 4;
  localparam int CW       = $clog2(MAX_OUTS + 1);

  logic                    clk, rst_n;
  logic [N_REQ-1:0]        req_valid_i, req_ready_o, req_rready_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [3:0]              arid_o, rid_i;
  logic [DATA_W-1:0]       ar_data_o;
  logic                    arvalid_o, arready_i, rvalid_i, rlast_i, rready_o;
  logic [N_REQ*CW-1:0]     outs_cnt_o;
  logic                    idle_o, err_o;

  sgdmac_ar_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_OUTS(MAX_OUTS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .arid_o(arid_o), .ar_data_o(ar_data_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rvalid_i(rvalid_i), .rlast_i(rlast_i), .rready_o(rready_o),
    .req_rready_i(req_rready_i), .outs_cnt_o(outs_cnt_o), .idle_o(idle_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Transaction-level model: outstanding burst counts, rotating priority, one pending AR.
  int                m_cnt [N_REQ];
  int                m_ptr, m_id;
  bit                m_busy, m_err;
  logic [DATA_W-1:0] m_data;
  logic [N_REQ-1:0]  exp_ready, obs_ready;
  logic              exp_rready, obs_rready;

  function automatic void model_reset();
    for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    m_ptr = 0; m_id = 0; m_busy = 0; m_err = 0; m_data = '0;
  endfunction

  function automatic void model_comb();
    int r;
    exp_ready = '0;
    if (!m_busy) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % N_REQ;
        if (req_valid_i[idx] && m_cnt[idx] < MAX_OUTS) begin
          exp_ready[idx] = 1'b1;
          break;
        end
      end
    end
    r = int'(rid_i);
    exp_rready = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (r == i) exp_rready = req_rready_i[i];
  endfunction

  function automatic void model_seq();
    int g, d, r;
    g = -1; d = -1; r = int'(rid_i);
    for (int i = 0; i < N_REQ; i++) if (exp_ready[i]) g = i;
    if (rvalid_i && exp_rready) begin
      if (r >= N_REQ) m_err = 1;
      else if (rlast_i) begin
        if (m_cnt[r] == 0) m_err = 1;
        else d = r;
      end
    end
    if (m_busy && arready_i) begin
      m_busy = 0;
      m_ptr  = (m_id + 1) % N_REQ;
    end else if (g >= 0) begin
      m_busy = 1;
      m_id   = g;
      m_data = req_data_i[g*DATA_W +: DATA_W];
    end
    if (g >= 0) m_cnt[g]++;
    if (d >= 0) m_cnt[d]--;
  endfunction

  function automatic int dut_cnt(int i);
    return int'(outs_cnt_o[i*CW +: CW]);
  endfunction

  // One clock: capture combinational outputs before the edge, then settle after it.
  task automatic tick();
    #1;
    model_comb();
    obs_ready  = req_ready_o;
    obs_rready = rready_o;
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic do_reset();
    req_valid_i = '0; req_rready_i = '0; req_data_i = '0;
    arready_i = 0; rvalid_i = 0; rlast_i = 0; rid_i = '0;
    @(negedge clk);
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pack(logic [31:0] a, logic [3:0] l, logic [2:0] s, logic [1:0] b);
    return {a, l, s, b};
  endfunction

  task automatic test_reset();
    do_reset();
    n_vec++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b exp 0", arvalid_o); end
    n_vec++; if (arid_o !== 4'd0) begin n_fail++; $display("FAIL reset_arid: got %0d exp 0", arid_o); end
    n_vec++; if (ar_data_o !== '0) begin n_fail++; $display("FAIL reset_ardata: got %h exp 0", ar_data_o); end
    n_vec++; if (outs_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h exp 0", outs_cnt_o); end
    n_vec++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b exp 1", idle_o); end
    n_vec++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err_o); end
    n_vec++; if (req_ready_o !== '0) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", req_ready_o); end
  endtask

  logic [DATA_W-1:0] held;

  task automatic test_single();
    held = pack(32'h1000, 4'd3, 3'd2, 2'd1);
    req_valid_i = 2'b01;
    req_data_i  = {pack(32'hDEAD_0000, 4'd7, 3'd1, 2'd0), held};
    tick();
    n_vec++; if (obs_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b exp 01", obs_ready); end
    n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_arvalid: got %b exp 1", arvalid_o); end
    n_vec++; if (arid_o !== 4'd0) begin n_fail++; $display("FAIL single_arid: got %0d exp 0", arid_o); end
    n_vec++; if (ar_data_o !== held) begin n_fail++; $display("FAIL single_ardata: got %h exp %h", ar_data_o, held); end
    n_vec++; if (dut_cnt(0) !== 1) begin n_fail++; $display("FAIL single_cnt0: got %0d exp 1", dut_cnt(0)); end
    req_valid_i = '0; req_data_i = '1; arready_i = 1;
    tick();
    n_vec++; if (obs_ready !== 2'b00) begin n_fail++; $display("FAIL single_no_regrant: got %b exp 00", obs_ready); end
    n_vec++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop: got %b exp 0", arvalid_o); end
    n_vec++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 0", idle_o); end
    arready_i = 0;
  endtask

  task automatic test_backpressure();
    held = pack(32'h0000_2040, 4'd15, 3'd3, 2'd1);
    req_valid_i = 2'b01; req_data_i = {pack(32'h1, 4'd1, 3'd1, 2'd1), held};
    tick();
    req_valid_i = 2'b11; req_data_i = {$urandom, $urandom, $urandom};
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++; if (obs_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready c%0d: got %b exp 00", c, obs_ready); end
      n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL bp_arvalid c%0d: got %b exp 1", c, arvalid_o); end
      n_vec++; if (ar_data_o !== held) begin n_fail++; $display("FAIL bp_ardata c%0d: got %h exp %h", c, ar_data_o, held); end
    end
    req_valid_i = '0; arready_i = 1;
    tick();
    arready_i = 0;
    n_vec++; if (dut_cnt(0) !== 2) begin n_fail++; $display("FAIL bp_cnt0: got %0d exp 2", dut_cnt(0)); end
  endtask

  task automatic test_simultaneous();
    req_valid_i = 2'b01; rvalid_i = 1; rlast_i = 1; rid_i = 4'd0; req_rready_i = 2'b01;
    tick();
    n_vec++; if (obs_ready !== 2'b01) begin n_fail++; $display("FAIL simul_ready: got %b exp 01", obs_ready); end
    n_vec++; if (obs_rready !== 1'b1) begin n_fail++; $display("FAIL simul_rready: got %b exp 1", obs_rready); end
    n_vec++; if (dut_cnt(0) !== 2) begin n_fail++; $display("FAIL simul_cnt0: got %0d exp 2", dut_cnt(0)); end
    req_valid_i = '0; rvalid_i = 0; rlast_i = 0; arready_i = 1;
    tick();
    arready_i = 0;
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] seq [8];
    seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    do_reset();
    req_valid_i = 2'b11; arready_i = 1;
    req_data_i = {pack(32'hB000, 4'd1, 3'd2, 2'd1), pack(32'hA000, 4'd0, 3'd2, 2'd1)};
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++; if (obs_ready !== seq[c]) begin n_fail++; $display("FAIL rr_ready c%0d: got %b exp %b", c, obs_ready, seq[c]); end
      if (c % 2 == 0) begin
        n_vec++; if (arid_o !== 4'((c / 2) % 2)) begin n_fail++; $display("FAIL rr_arid c%0d: got %0d exp %0d", c, arid_o, (c / 2) % 2); end
      end
    end
    req_valid_i = '0; arready_i = 0;
  endtask

  task automatic test_limit();
    int grants;
    do_reset();
    grants = 0;
    req_valid_i = 2'b10; arready_i = 1; req_data_i = {$urandom, $urandom, $urandom};
    for (int c = 0; c < 12; c++) begin
      tick();
      if (obs_ready[1]) grants++;
    end
    n_vec++; if (grants !== MAX_OUTS) begin n_fail++; $display("FAIL limit_grants: got %0d exp %0d", grants, MAX_OUTS); end
    n_vec++; if (dut_cnt(1) !== MAX_OUTS) begin n_fail++; $display("FAIL limit_cnt1: got %0d exp %0d", dut_cnt(1), MAX_OUTS); end
    rvalid_i = 1; rlast_i = 1; rid_i = 4'd1; req_rready_i = 2'b10;
    tick();
    n_vec++; if (obs_ready !== 2'b00) begin n_fail++; $display("FAIL limit_masked: got %b exp 00", obs_ready); end
    n_vec++; if (dut_cnt(1) !== MAX_OUTS - 1) begin n_fail++; $display("FAIL limit_dec: got %0d exp %0d", dut_cnt(1), MAX_OUTS - 1); end
    rvalid_i = 0; rlast_i = 0;
    tick();
    n_vec++; if (obs_ready !== 2'b10) begin n_fail++; $display("FAIL limit_regrant: got %b exp 10", obs_ready); end
    req_valid_i = '0;
    tick();
    arready_i = 0;
  endtask

  task automatic test_r_routing();
    do_reset();
    rvalid_i = 1; rlast_i = 0; rid_i = 4'd1; req_rready_i = 2'b10;
    tick();
    n_vec++; if (obs_rready !== 1'b1) begin n_fail++; $display("FAIL route_rid1: got %b exp 1", obs_rready); end
    rid_i = 4'd0;
    tick();
    n_vec++; if (obs_rready !== 1'b0) begin n_fail++; $display("FAIL route_rid0: got %b exp 0", obs_rready); end
    n_vec++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL route_err_clean: got %b exp 0", err_o); end
    rid_i = 4'd5;
    tick();
    n_vec++; if (obs_rready !== 1'b1) begin n_fail++; $display("FAIL route_drain: got %b exp 1", obs_rready); end
    n_vec++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL route_err_set: got %b exp 1", err_o); end
    rvalid_i = 0; rid_i = 4'd0;
    repeat (3) tick();
    n_vec++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL route_err_sticky: got %b exp 1", err_o); end
    do_reset();
    rvalid_i = 1; rlast_i = 1; rid_i = 4'd0; req_rready_i = 2'b01;
    tick();
    rvalid_i = 0; rlast_i = 0;
    n_vec++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b exp 1", err_o); end
    n_vec++; if (dut_cnt(0) !== 0) begin n_fail++; $display("FAIL underflow_cnt: got %0d exp 0", dut_cnt(0)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid_i = 2'b10; req_data_i = {$urandom, $urandom, $urandom};
    tick();
    n_vec++; if (arvalid_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got %b exp 1", arvalid_o); end
    #1 rst_n = 0;
    #1;
    n_vec++; if (arvalid_o !== 1'b0) begin n_fail++; $display("FAIL areset_arvalid: got %b exp 0", arvalid_o); end
    n_vec++; if (outs_cnt_o !== '0) begin n_fail++; $display("FAIL areset_cnt: got %h exp 0", outs_cnt_o); end
    do_reset();
  endtask

  task automatic test_random();
    bit exp_idle;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid_i  = N_REQ'($urandom);
      req_data_i   = {$urandom, $urandom, $urandom};
      arready_i    = ($urandom_range(0, 3) != 0);
      rvalid_i     = $urandom_range(0, 1);
      rlast_i      = $urandom_range(0, 1);
      rid_i        = ($urandom_range(0, 63) == 0) ? 4'd9 : 4'($urandom_range(0, N_REQ - 1));
      req_rready_i = N_REQ'($urandom);
      tick();
      exp_idle = !m_busy;
      for (int i = 0; i < N_REQ; i++) if (m_cnt[i] != 0) exp_idle = 0;
      n_vec++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got %b exp %b", c, obs_ready, exp_ready); end
      n_vec++; if (obs_rready !== exp_rready) begin n_fail++; $display("FAIL rand_rready c%0d: got %b exp %b", c, obs_rready, exp_rready); end
      n_vec++; if (arvalid_o !== m_busy) begin n_fail++; $display("FAIL rand_arvalid c%0d: got %b exp %b", c, arvalid_o, m_busy); end
      n_vec++; if (arid_o !== 4'(m_id)) begin n_fail++; $display("FAIL rand_arid c%0d: got %0d exp %0d", c, arid_o, m_id); end
      n_vec++; if (ar_data_o !== m_data) begin n_fail++; $display("FAIL rand_ardata c%0d: got %h exp %h", c, ar_data_o, m_data); end
      for (int i = 0; i < N_REQ; i++) begin
        n_vec++; if (dut_cnt(i) !== m_cnt[i]) begin n_fail++; $display("FAIL rand_cnt%0d c%0d: got %0d exp %0d", i, c, dut_cnt(i), m_cnt[i]); end
      end
      n_vec++; if (idle_o !== exp_idle) begin n_fail++; $display("FAIL rand_idle c%0d: got %b exp %b", c, idle_o, exp_idle); end
      n_vec++; if (err_o !== m_err) begin n_fail++; $display("FAIL rand_err c%0d: got %b exp %b", c, err_o, m_err); end
    end
  endtask

  initial begin
    rst_n = 1;
    test_reset();
    test_single();
    test_backpressure();
    test_simultaneous();
    test_round_robin();
    test_limit();
    test_r_routing();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
